// File: rtl/insn_decoder.sv
// insn_decoder: decode stage behind the instruction fetcher.
// Splits the instruction word into fields, sign-extends the immediate,
// tracks pending register writes with a busy-bit scoreboard and presents
// one registered decoded instruction per cycle over a valid/stall handshake.
// Optional build macro: INSN_DECODER_WB_BYPASS_EN lets a writeback in the
// current cycle release a dependent instruction in that same cycle.
module insn_decoder #(
    parameter int LEN_INSN      = 32,
    parameter int MEM_INSN_ADDR = 10,
    parameter int LEN_OPCODE    = 6,
    parameter int LEN_REGNO     = 5,
    parameter int LEN_WORD      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     stall_o,
    input  logic [LEN_INSN-1:0]      insn_i,
    input  logic [MEM_INSN_ADDR-1:0] addr_i,
    output logic                     valid_o,
    input  logic                     stall_i,
    output logic [LEN_OPCODE-1:0]    op_o,
    output logic [LEN_REGNO-1:0]     rd_o,
    output logic [LEN_REGNO-1:0]     rs_o,
    output logic [LEN_REGNO-1:0]     rt_o,
    output logic [LEN_WORD-1:0]      imm_o,
    output logic                     wr_en_o,
    output logic [MEM_INSN_ADDR-1:0] addr_o,
    input  logic                     wb_valid_i,
    input  logic [LEN_REGNO-1:0]     wb_regno_i
);

    localparam int NUM_REGS = 2 ** LEN_REGNO;
    localparam int LEN_IMM  = 16;
    localparam int RD_MSB   = LEN_INSN - LEN_OPCODE - 1;
    localparam int RS_MSB   = RD_MSB - LEN_REGNO;
    localparam int RT_MSB   = RS_MSB - LEN_REGNO;

    // Decoded fields of insn_i
    logic [LEN_OPCODE-1:0] dec_op;
    logic [LEN_REGNO-1:0]  dec_rd;
    logic [LEN_REGNO-1:0]  dec_rs;
    logic [LEN_REGNO-1:0]  dec_rt;
    logic [LEN_WORD-1:0]   dec_imm;
    logic                  dec_writes;

    // Handshake
    logic hazard;
    logic out_block;
    logic accept;

    // Scoreboard
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] busy_eff;

    // Output register
    logic                     valid_q, valid_d;
    logic [LEN_OPCODE-1:0]    op_q, op_d;
    logic [LEN_REGNO-1:0]     rd_q, rd_d;
    logic [LEN_REGNO-1:0]     rs_q, rs_d;
    logic [LEN_REGNO-1:0]     rt_q, rt_d;
    logic [LEN_WORD-1:0]      imm_q, imm_d;
    logic                     wr_en_q, wr_en_d;
    logic [MEM_INSN_ADDR-1:0] addr_q, addr_d;

    // Split the instruction word into its fields
    always_comb begin
        dec_op     = insn_i[LEN_INSN-1 -: LEN_OPCODE];
        dec_rd     = insn_i[RD_MSB -: LEN_REGNO];
        dec_rs     = insn_i[RS_MSB -: LEN_REGNO];
        dec_rt     = insn_i[RT_MSB -: LEN_REGNO];
        dec_imm    = {{(LEN_WORD-LEN_IMM){insn_i[LEN_IMM-1]}}, insn_i[LEN_IMM-1:0]};
        // Opcodes with the top bit set never write; r0 is a write sink.
        dec_writes = !dec_op[LEN_OPCODE-1] && (dec_rd != '0);
    end

    // Busy view seen by the hazard check (optionally bypassing this cycle's writeback)
    always_comb begin
        busy_eff = busy_q;
`ifdef INSN_DECODER_WB_BYPASS_EN
        if (wb_valid_i) begin
            busy_eff[wb_regno_i] = 1'b0;
        end
`endif
    end

    // Hazard detection and valid/stall handshake toward upstream
    always_comb begin
        hazard    = valid_i && (busy_eff[dec_rs] || busy_eff[dec_rt]
                                || (dec_writes && busy_eff[dec_rd]));
        out_block = valid_q && stall_i;
        stall_o   = valid_i && (hazard || out_block);
        accept    = valid_i && !stall_o;
    end

    // Next state of the output register: load on accept, bubble when free, hold when blocked
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        imm_d   = imm_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        if (accept) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            rd_d    = dec_rd;
            rs_d    = dec_rs;
            rt_d    = dec_rt;
            imm_d   = dec_imm;
            wr_en_d = dec_writes;
            addr_d  = addr_i;
        end else if (!out_block) begin
            valid_d = 1'b0;
        end
    end

    // Scoreboard next state: clear on writeback, then set on accepted writer so set wins
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i && (wb_regno_i != '0)) begin
            busy_d[wb_regno_i] = 1'b0;
        end
        if (accept && dec_writes) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
        end
    end

    // Scoreboard busy bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: busy bits are plain flops, not a RAM, so they must be reset; a stale bit would deadlock issue.
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign rd_o    = rd_q;
    assign rs_o    = rs_q;
    assign rt_o    = rt_q;
    assign imm_o   = imm_q;
    assign wr_en_o = wr_en_q;
    assign addr_o  = addr_q;

endmodule
